// File: rtl/cotm32_pkg.sv
// Shared types and constants for the cotm32 core control path.
package cotm32_pkg;

    // Sequencer states. o_state exposes the encoding directly.
    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM        = 3'd3,
        MEM_WAIT   = 3'd4,
        WB         = 3'd5,
        TRAP       = 3'd6
    } core_seq_state_t;

    // Which handshake timed out.
    typedef enum logic [1:0] {
        FAULT_FETCH = 2'd0,
        FAULT_LOAD  = 2'd1,
        FAULT_STORE = 2'd2
    } bus_fault_kind_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Default bound on any single memory handshake wait.
    localparam int SEQ_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/seq_timeout_counter.sv
// Wait-cycle counter for memory handshakes. expire is high during the
// TIMEOUT_CYCLES-th consecutive enabled cycle, so the state leaving on
// expire lands in its successor exactly TIMEOUT_CYCLES cycles after entry.
// TIMEOUT_CYCLES = 0 never expires.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count waiting cycles; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetch over a variable-latency IMEM, execute,
// optional DMEM access, then a single writeback (or trap) cycle that carries
// every architectural commit strobe.
//
// Memory handshake: the sequencer holds req high until it sees gnt in the same
// cycle (request accepted); the response is the first rvalid seen in or after
// the gnt cycle. rvalid is only looked at from the gnt cycle onward, and
// gnt/rvalid arriving while nothing is outstanding are ignored.
module core_sequencer #(
    parameter int XLEN           = 32,
    parameter int INST_WIDTH     = 32,
    parameter int INSTRET_WIDTH  = 64,
    parameter int TIMEOUT_CYCLES = cotm32_pkg::SEQ_TIMEOUT_CYCLES,
    parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(cotm32_pkg::NOP_INST)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_halt,
    output logic                     o_imem_req,
    input  logic                     i_imem_gnt,
    input  logic                     i_imem_rvalid,
    input  logic [INST_WIDTH-1:0]    i_imem_rdata,
    output logic [INST_WIDTH-1:0]    o_inst,
    input  logic                     i_is_load,
    input  logic                     i_is_store,
    input  logic                     i_regfile_we_dec,
    input  logic                     i_csr_we_dec,
    input  logic                     i_mret,
    input  logic                     i_trap_req,
    output logic                     o_dmem_req,
    input  logic                     i_dmem_gnt,
    input  logic                     i_dmem_rvalid,
    input  logic [XLEN-1:0]          i_dmem_rdata,
    output logic [XLEN-1:0]          o_load_data,
    output logic                     o_pc_we,
    output logic                     o_regfile_we,
    output logic                     o_csr_we,
    output logic                     o_mret_commit,
    output logic                     o_trap_commit,
    output logic                     o_bus_fault,
    output logic [1:0]               o_bus_fault_kind,
    output logic [INSTRET_WIDTH-1:0] o_instret,
    output logic                     o_busy,
    output logic [2:0]               o_state
);

    import cotm32_pkg::*;

    core_seq_state_t state_q, state_d;
    bus_fault_kind_t kind_q, kind_d;

    // Decode bits captured in EXEC so later cycles do not depend on decoder timing.
    logic ld_q, rf_q, csr_q, mret_q;
    logic fault_q;
    logic inst_we, load_we;
    logic wait_en, tmo_clr, expire;

    // A cycle counts as waiting when its state's handshake did not complete.
    assign wait_en = ((state_q == FETCH)      && !i_halt && !i_imem_gnt)
                   || ((state_q == FETCH_WAIT) && !i_imem_rvalid)
                   || ((state_q == MEM)        && !i_dmem_gnt)
                   || ((state_q == MEM_WAIT)   && !i_dmem_rvalid);

    // Restart the count on every state change; a halted FETCH is idle, not waiting.
    assign tmo_clr = (state_d != state_q) || ((state_q == FETCH) && i_halt);

    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (tmo_clr),
        .en    (wait_en),
        .expire(expire)
    );

    // Next-state, request and commit-strobe decode.
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        inst_we       = 1'b0;
        load_we       = 1'b0;
        o_imem_req    = 1'b0;
        o_dmem_req    = 1'b0;
        o_pc_we       = 1'b0;
        o_regfile_we  = 1'b0;
        o_csr_we      = 1'b0;
        o_mret_commit = 1'b0;
        o_trap_commit = 1'b0;
        o_bus_fault   = 1'b0;
        case (state_q)
            FETCH: begin
                if (!i_halt) begin
                    o_imem_req = !i_rst;
                    if (i_imem_gnt) begin
                        if (i_imem_rvalid) begin
                            inst_we = 1'b1;
                            state_d = EXEC;
                        end else begin
                            state_d = FETCH_WAIT;
                        end
                    end else if (expire) begin
                        kind_d  = FAULT_FETCH;
                        state_d = TRAP;
                    end
                end
            end
            FETCH_WAIT: begin
                if (i_imem_rvalid) begin
                    inst_we = 1'b1;
                    state_d = EXEC;
                end else if (expire) begin
                    kind_d  = FAULT_FETCH;
                    state_d = TRAP;
                end
            end
            EXEC: begin
                if (i_trap_req) begin
                    state_d = TRAP;
                end else if (i_is_load || i_is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                o_dmem_req = 1'b1;
                if (i_dmem_gnt) begin
                    if (!ld_q) begin
                        state_d = WB;
                    end else if (i_dmem_rvalid) begin
                        load_we = 1'b1;
                        state_d = WB;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else if (expire) begin
                    kind_d  = ld_q ? FAULT_LOAD : FAULT_STORE;
                    state_d = TRAP;
                end
            end
            MEM_WAIT: begin
                if (i_dmem_rvalid) begin
                    load_we = 1'b1;
                    state_d = WB;
                end else if (expire) begin
                    kind_d  = FAULT_LOAD;
                    state_d = TRAP;
                end
            end
            WB: begin
                o_pc_we       = 1'b1;
                o_regfile_we  = rf_q;
                o_csr_we      = csr_q;
                o_mret_commit = mret_q;
                state_d       = FETCH;
            end
            TRAP: begin
                o_pc_we       = 1'b1;
                o_trap_commit = 1'b1;
                o_bus_fault   = fault_q;
                state_d       = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // State, latched instruction/load data, decode capture and retire counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= FETCH;
            kind_q      <= FAULT_FETCH;
            fault_q     <= 1'b0;
            o_inst      <= NOP_INST;
            o_load_data <= '0;
            o_instret   <= '0;
            ld_q        <= 1'b0;
            rf_q        <= 1'b0;
            csr_q       <= 1'b0;
            mret_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            fault_q <= expire;
            if (inst_we) begin
                o_inst <= i_imem_rdata;
            end
            if (load_we) begin
                o_load_data <= i_dmem_rdata;
            end
            if (state_q == EXEC) begin
                ld_q   <= i_is_load;
                rf_q   <= i_regfile_we_dec;
                csr_q  <= i_csr_we_dec;
                mret_q <= i_mret;
            end
            if (state_q == WB) begin
                o_instret <= o_instret + 1'b1;
            end
        end
    end

    assign o_bus_fault_kind = kind_q;
    assign o_busy           = !((state_q == FETCH) && i_halt);
    assign o_state          = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer with a short handshake timeout (4 cycles).
module tb_core_sequencer;
    import cotm32_pkg::*;

    localparam int REC_W = 136;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] LW   = 32'h0000_A103;
    localparam logic [31:0] SW   = 32'h0020_A223;

    logic        i_clk = 1'b0;
    logic        i_rst, i_halt;
    logic        o_imem_req, i_imem_gnt, i_imem_rvalid;
    logic [31:0] i_imem_rdata, o_inst;
    logic        i_is_load, i_is_store, i_regfile_we_dec, i_csr_we_dec, i_mret, i_trap_req;
    logic        o_dmem_req, i_dmem_gnt, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata, o_load_data;
    logic        o_pc_we, o_regfile_we, o_csr_we, o_mret_commit, o_trap_commit, o_bus_fault;
    logic [1:0]  o_bus_fault_kind;
    logic [63:0] o_instret;
    logic        o_busy;
    logic [2:0]  o_state;

    int vectors = 0;
    int miscompares = 0;

    // Model state and scoreboard
    logic [31:0]      exp_ld;
    logic [63:0]      exp_instret;
    logic [1:0]       exp_kind;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] obs_q[$];
    logic [REC_W-1:0] rec_e, rec_o;

    // Monitor counters (written only by the monitor)
    int strobe_bad = 0;
    int rf_pulses = 0;
    int dmem_req_cycles = 0;
    int mw_cycles = 0;

    always #5 i_clk = ~i_clk;

    core_sequencer #(
        .XLEN(32), .INST_WIDTH(32), .INSTRET_WIDTH(64), .TIMEOUT_CYCLES(4), .NOP_INST(NOP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_halt(i_halt),
        .o_imem_req(o_imem_req), .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata(i_imem_rdata), .o_inst(o_inst),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_regfile_we_dec(i_regfile_we_dec),
        .i_csr_we_dec(i_csr_we_dec), .i_mret(i_mret), .i_trap_req(i_trap_req),
        .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata(i_dmem_rdata), .o_load_data(o_load_data),
        .o_pc_we(o_pc_we), .o_regfile_we(o_regfile_we), .o_csr_we(o_csr_we),
        .o_mret_commit(o_mret_commit), .o_trap_commit(o_trap_commit),
        .o_bus_fault(o_bus_fault), .o_bus_fault_kind(o_bus_fault_kind),
        .o_instret(o_instret), .o_busy(o_busy), .o_state(o_state)
    );

    // Monitor: strobes outside WB/TRAP, regfile pulses, DMEM requests, MEM_WAIT residency
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if ((o_pc_we | o_regfile_we | o_csr_we | o_mret_commit | o_trap_commit | o_bus_fault)
                && !(o_state == WB || o_state == TRAP)) strobe_bad++;
            if (o_regfile_we) rf_pulses++;
            if (o_dmem_req) dmem_req_cycles++;
            if (o_state == MEM_WAIT) mw_cycles++;
        end
    end

    function automatic logic [REC_W-1:0] snap();
        return {o_pc_we, o_trap_commit, o_bus_fault, o_bus_fault_kind, o_regfile_we,
                o_csr_we, o_mret_commit, o_inst, o_load_data, o_instret};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
        i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = '0;
        i_is_load = 0; i_is_store = 0; i_regfile_we_dec = 0;
        i_csr_we_dec = 0; i_mret = 0; i_trap_req = 0;
    endtask

    // Driver: one instruction from FETCH (entered #1 after a posedge) back to FETCH.
    // kind: 0 alu, 1 load, 2 store. Pushes expected commit and captures observed commit.
    task automatic run_instr(input int kind, input logic trap, input logic rf, input logic csr,
                             input logic mret, input int fg, input int fr, input logic stray,
                             input logic [31:0] inst, input int dg, input int dr,
                             input logic [31:0] ld);
        i_halt = 0;
        i_is_load = (kind == 1); i_is_store = (kind == 2);
        i_regfile_we_dec = rf; i_csr_we_dec = csr; i_mret = mret; i_trap_req = trap;
        for (int c = 0; c < fg; c++) begin
            i_imem_rvalid = stray; i_imem_rdata = ~inst;
            step();
        end
        i_imem_gnt = 1; i_imem_rvalid = (fr == 0); i_imem_rdata = inst;
        step();
        i_imem_gnt = 0; i_imem_rvalid = 0;
        if (fr > 0) begin
            for (int c = 0; c < fr - 1; c++) step();
            i_imem_rvalid = 1;
            step();
            i_imem_rvalid = 0;
        end
        step();  // leave EXEC
        if (kind != 0 && !trap) begin
            for (int c = 0; c < dg; c++) step();
            i_dmem_gnt = 1; i_dmem_rvalid = (kind == 1 && dr == 0); i_dmem_rdata = ld;
            step();
            i_dmem_gnt = 0; i_dmem_rvalid = 0;
            if (kind == 1 && dr > 0) begin
                for (int c = 0; c < dr - 1; c++) step();
                i_dmem_rvalid = 1;
                step();
                i_dmem_rvalid = 0;
            end
        end
        @(negedge i_clk);
        obs_q.push_back(snap());
        if (kind == 1 && !trap) exp_ld = ld;
        exp_q.push_back({1'b1, trap, 1'b0, exp_kind, rf & !trap, csr & !trap, mret & !trap,
                         inst, exp_ld, exp_instret});
        if (!trap) exp_instret = exp_instret + 64'd1;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1; i_halt = 1;
        repeat (3) @(posedge i_clk);
        #1;
        vectors++;
        if ({o_state, o_inst, o_load_data, o_instret} !== {3'(FETCH), NOP, 32'd0, 64'd0}) begin
            miscompares++;
            $display("FAIL reset_regs: got st=%0d inst=%h ld=%h ret=%0d", o_state, o_inst, o_load_data, o_instret);
        end
        vectors++;
        if ({o_imem_req, o_dmem_req, o_pc_we, o_regfile_we, o_csr_we, o_mret_commit,
             o_trap_commit, o_bus_fault, o_bus_fault_kind} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_strobes: got req=%b/%b pc=%b rf=%b kind=%0d", o_imem_req, o_dmem_req, o_pc_we, o_regfile_we, o_bus_fault_kind);
        end
        exp_ld = 0; exp_instret = 0; exp_kind = 0;
        @(negedge i_clk);
        i_rst = 0;
        step();
    endtask

    task automatic test_zero_wait();
        i_halt = 0; i_regfile_we_dec = 1;
        i_imem_gnt = 1; i_imem_rvalid = 1; i_imem_rdata = ADDI;
        @(negedge i_clk);
        vectors++;
        if ({o_state, o_imem_req, o_regfile_we} !== {3'(FETCH), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL zw_cycle1: got st=%0d req=%b rf=%b exp st=0 req=1 rf=0", o_state, o_imem_req, o_regfile_we);
        end
        step();
        i_imem_gnt = 0; i_imem_rvalid = 0;
        @(negedge i_clk);
        vectors++;
        if ({o_state, o_inst, o_regfile_we} !== {3'(EXEC), ADDI, 1'b0}) begin
            miscompares++;
            $display("FAIL zw_cycle2: got st=%0d inst=%h rf=%b exp st=2 inst=%h rf=0", o_state, o_inst, o_regfile_we, ADDI);
        end
        step();
        @(negedge i_clk);
        vectors++;
        if ({o_state, o_regfile_we, o_pc_we, o_instret} !== {3'(WB), 1'b1, 1'b1, 64'd0}) begin
            miscompares++;
            $display("FAIL zw_cycle3: got st=%0d rf=%b pc=%b ret=%0d exp st=5 rf=1 pc=1 ret=0", o_state, o_regfile_we, o_pc_we, o_instret);
        end
        step();
        @(negedge i_clk);
        vectors++;
        if ({o_state, o_regfile_we, o_instret} !== {3'(FETCH), 1'b0, 64'd1}) begin
            miscompares++;
            $display("FAIL zw_cycle4: got st=%0d rf=%b ret=%0d exp st=0 rf=0 ret=1", o_state, o_regfile_we, o_instret);
        end
        exp_instret = 1;
        i_regfile_we_dec = 0; i_halt = 1;
        step();
    endtask

    task automatic test_wait_states();
        int rf0;
        rf0 = rf_pulses;
        run_instr(1, 0, 1, 0, 0, 2, 1, 1, LW, 1, 3, 32'hDEAD_BEEF);
        while (exp_q.size() > 0) begin
            rec_e = exp_q.pop_front();
            rec_o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            vectors++;
            if (rec_o !== rec_e) begin miscompares++; $display("FAIL wait_commit: got %h exp %h", rec_o, rec_e); end
        end
        vectors++;
        if (rf_pulses - rf0 !== 1) begin miscompares++; $display("FAIL wait_rf_pulses: got %0d exp 1", rf_pulses - rf0); end
        vectors++;
        if ({o_inst, o_load_data, o_instret} !== {LW, 32'hDEAD_BEEF, exp_instret}) begin
            miscompares++;
            $display("FAIL wait_latched: got inst=%h ld=%h ret=%0d exp %h %h %0d", o_inst, o_load_data, o_instret, LW, 32'hDEAD_BEEF, exp_instret);
        end
    endtask

    task automatic test_store();
        int mw0;
        mw0 = mw_cycles;
        run_instr(2, 0, 0, 0, 0, 0, 0, 0, SW, 1, 0, 32'h1234_5678);
        while (exp_q.size() > 0) begin
            rec_e = exp_q.pop_front();
            rec_o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            vectors++;
            if (rec_o !== rec_e) begin miscompares++; $display("FAIL store_commit: got %h exp %h", rec_o, rec_e); end
        end
        vectors++;
        if (mw_cycles - mw0 !== 0) begin miscompares++; $display("FAIL store_no_memwait: got %0d cycles exp 0", mw_cycles - mw0); end
        vectors++;
        if (o_instret !== exp_instret) begin miscompares++; $display("FAIL store_instret: got %0d exp %0d", o_instret, exp_instret); end
    endtask

    task automatic test_trap();
        int d0;
        d0 = dmem_req_cycles;
        run_instr(1, 1, 1, 1, 0, 0, 0, 0, LW, 0, 0, 32'hBAD0_BAD0);
        while (exp_q.size() > 0) begin
            rec_e = exp_q.pop_front();
            rec_o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            vectors++;
            if (rec_o !== rec_e) begin miscompares++; $display("FAIL trap_commit: got %h exp %h", rec_o, rec_e); end
        end
        vectors++;
        if (dmem_req_cycles - d0 !== 0) begin miscompares++; $display("FAIL trap_no_dmem_req: got %0d cycles exp 0", dmem_req_cycles - d0); end
        vectors++;
        if (o_instret !== exp_instret) begin miscompares++; $display("FAIL trap_instret: got %0d exp %0d", o_instret, exp_instret); end
    endtask

    task automatic test_timeout();
        int k;
        logic [2:0] st_f;
        logic req_f;
        k = -1; st_f = '0; req_f = 1'b1;
        i_halt = 0; i_is_load = 1; i_regfile_we_dec = 1;
        i_imem_gnt = 1; i_imem_rvalid = 1; i_imem_rdata = LW;
        step();
        i_imem_gnt = 0; i_imem_rvalid = 0;
        step();  // MEM entry; DMEM never grants
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_bus_fault) begin
                k = c; st_f = o_state; req_f = o_dmem_req;
                obs_q.push_back(snap());
                break;
            end
            @(posedge i_clk);
            #1;
        end
        vectors++;
        if (k != 4) begin miscompares++; $display("FAIL timeout_latency: got %0d cycles exp 4", k); end
        if (k >= 0) begin
            exp_kind = 2'd1;
            exp_q.push_back({1'b1, 1'b1, 1'b1, exp_kind, 3'b000, LW, exp_ld, exp_instret});
            vectors++;
            if ({st_f, req_f} !== {3'(TRAP), 1'b0}) begin
                miscompares++;
                $display("FAIL timeout_fault_cycle: got st=%0d req=%b exp st=6 req=0", st_f, req_f);
            end
            step();
        end
        clear_inputs();
        while (exp_q.size() > 0) begin
            rec_e = exp_q.pop_front();
            rec_o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            vectors++;
            if (rec_o !== rec_e) begin miscompares++; $display("FAIL timeout_commit: got %h exp %h", rec_o, rec_e); end
        end
        vectors++;
        if ({o_state, o_dmem_req, o_bus_fault_kind} !== {3'(FETCH), 1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL timeout_after: got st=%0d req=%b kind=%0d exp st=0 req=0 kind=1", o_state, o_dmem_req, o_bus_fault_kind);
        end
    endtask

    task automatic test_reset_mid();
        i_halt = 0; i_is_load = 1; i_regfile_we_dec = 1;
        i_imem_gnt = 1; i_imem_rvalid = 1; i_imem_rdata = LW;
        step();
        i_imem_gnt = 0; i_imem_rvalid = 0;
        step();
        i_dmem_gnt = 1;
        step();
        i_dmem_gnt = 0;
        step();
        @(negedge i_clk);
        vectors++;
        if (o_state !== 3'(MEM_WAIT)) begin miscompares++; $display("FAIL rst_mid_setup: got st=%0d exp 4", o_state); end
        #2 i_rst = 1; i_halt = 1;
        #1;
        vectors++;
        if ({o_state, o_inst, o_load_data, o_instret, o_imem_req, o_dmem_req, o_bus_fault_kind}
            !== {3'(FETCH), NOP, 32'hDEAD_BEEF & 32'd0, 64'd0, 1'b0, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_async: got st=%0d inst=%h ld=%h ret=%0d req=%b/%b kind=%0d",
                     o_state, o_inst, o_load_data, o_instret, o_imem_req, o_dmem_req, o_bus_fault_kind);
        end
        exp_ld = 0; exp_instret = 0; exp_kind = 0;
        clear_inputs();
        @(negedge i_clk);
        i_rst = 0;
        step();
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFE_F00D;
        i_imem_rvalid = 1; i_imem_rdata = 32'hFFFF_FFFF;
        step();
        i_dmem_rvalid = 0; i_imem_rvalid = 0;
        @(negedge i_clk);
        vectors++;
        if ({o_state, o_load_data, o_inst, o_instret, o_imem_req, o_busy}
            !== {3'(FETCH), 32'd0, NOP, 64'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL stray_and_halt: got st=%0d ld=%h inst=%h ret=%0d req=%b busy=%b",
                     o_state, o_load_data, o_inst, o_instret, o_imem_req, o_busy);
        end
        i_halt = 0;
        #1;
        vectors++;
        if ({o_imem_req, o_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL unhalt: got req=%b busy=%b exp 1 1", o_imem_req, o_busy);
        end
        i_halt = 1;
        step();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 12; n++) begin
            run_instr($urandom_range(0, 2), ($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      $urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
        end
        while (exp_q.size() > 0) begin
            rec_e = exp_q.pop_front();
            rec_o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            vectors++;
            if (rec_o !== rec_e) begin miscompares++; $display("FAIL b2b_commit: got %h exp %h", rec_o, rec_e); end
        end
        vectors++;
        if (o_instret !== exp_instret) begin miscompares++; $display("FAIL b2b_instret: got %0d exp %0d", o_instret, exp_instret); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_store();
        test_trap();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (strobe_bad !== 0) begin miscompares++; $display("FAIL strobe_outside_wb_trap: got %0d cycles exp 0", strobe_bad); end
        vectors++;
        if (obs_q.size() !== 0) begin miscompares++; $display("FAIL extra_commits: got %0d exp 0", obs_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
